// File: rtl/load_store_unit.sv
// Load/store unit between the core controller and a word-addressed data memory.
// Issues only full-word memory accesses; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RMW_RD  = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    // Misalignment and illegal-encoding check for a request.
    function automatic logic req_is_error(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] a);
        logic err;
        err = 1'b0;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = a[0];
            3'b010:  err = (a != 2'b00);
            3'b100:  err = wr;
            3'b101:  err = wr | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Select the addressed byte/halfword lane and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the store bytes on the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] res;
        mask = 32'h000000FF << {off, 3'b000};
        case (f3)
            3'b000:  res = (word & ~mask) | ({24'h000000, wdata[7:0]} << {off, 3'b000});
            3'b001:  res = off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_data_d    = wr_data_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    addr_d   = {req_addr[31:2], 2'b00};
                    wdata_d  = req_wdata;
                    cnt_d    = 2'd0;
                    if (req_is_error(req_write, req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else if (!req_write) begin
                        state_d = ST_RD_WAIT;
                    end else if (req_funct3 == 3'b010) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        wr_data_d   = req_wdata;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d      = ST_RESP;
                    cnt_d        = 2'd0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = load_extract(mem_read_data, funct3_q, off_q);
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RMW_RD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_WR;
                    cnt_d       = 2'd0;
                    mem_write_d = 1'b1;
                    wr_data_d   = store_merge(mem_read_data, wdata_q, funct3_q, off_q);
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'h0000_0000;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            mem_write_q  <= 1'b0;
            wr_data_q    <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_write_q  <= mem_write_d;
            wr_data_q    <= wr_data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready         = (state_q == ST_IDLE) & ~reset;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_error        = resp_error_q;
    assign mem_write         = mem_write_q;
    assign mem_funct3        = 3'b010;
    assign mem_write_address = addr_q;
    assign mem_read_address  = addr_q;
    assign mem_write_data    = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (latency 1 and 3), each with a
// small behavioural word memory, and a scoreboard queue of expected responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst           [2];
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic        req_write     [2];
    logic [2:0]  req_funct3    [2];
    logic [31:0] req_addr      [2];
    logic [31:0] req_wdata     [2];
    logic        resp_valid    [2];
    logic [31:0] resp_rdata    [2];
    logic        resp_error    [2];
    logic        mem_write     [2];
    logic [2:0]  mem_funct3    [2];
    logic [31:0] mem_waddr     [2];
    logic [31:0] mem_wdata     [2];
    logic [31:0] mem_raddr     [2];
    logic [31:0] mem_rdata     [2];

    logic [31:0] mem [2][256];
    logic        bk_we;
    int          bk_sel;
    logic [7:0]  bk_idx;
    logic [31:0] bk_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          resp_lat;
        int          wr_lat;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit #(.MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]),
        .mem_write(mem_write[0]), .mem_funct3(mem_funct3[0]),
        .mem_write_address(mem_waddr[0]), .mem_write_data(mem_wdata[0]),
        .mem_read_address(mem_raddr[0]), .mem_read_data(mem_rdata[0])
    );

    load_store_unit #(.MEM_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]),
        .mem_write(mem_write[1]), .mem_funct3(mem_funct3[1]),
        .mem_write_address(mem_waddr[1]), .mem_write_data(mem_wdata[1]),
        .mem_read_address(mem_raddr[1]), .mem_read_data(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is held stable by the unit's stable address, so a combinational read suffices.
    assign mem_rdata[0] = mem[0][mem_raddr[0][9:2]];
    assign mem_rdata[1] = mem[1][mem_raddr[1][9:2]];

    // Memory write port plus backdoor preload.
    always @(posedge clk) begin
        if (bk_we) mem[bk_sel][bk_idx] <= bk_data;
        for (int i = 0; i < 2; i++)
            if (mem_write[i]) mem[i][mem_waddr[i][9:2]] <= mem_wdata[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int sel, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_sel = sel; bk_idx = a[9:2]; bk_data = d;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    // Issue one request, then watch outputs cycle by cycle after the accept edge (k=1 is T+1).
    task automatic run(input int sel, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int resp_lat, input int wr_lat, input logic [31:0] exp_wdata);
        exp_t e;
        int   nwr, wk, rk;
        logic got;
        logic [31:0] held;
        sb_q.push_back('{exp_rdata, exp_err, resp_lat, wr_lat, {a[31:2], 2'b00}, exp_wdata});
        @(negedge clk);
        chk("ready_idle", 32'(req_ready[sel]), 32'd1);
        req_valid[sel] = 1'b1; req_write[sel] = w; req_funct3[sel] = f3;
        req_addr[sel] = a; req_wdata[sel] = wd;
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
        req_addr[sel] = $urandom; req_wdata[sel] = $urandom; req_funct3[sel] = 3'($urandom);
        nwr = 0; wk = 0; rk = 0; got = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (mem_write[sel]) begin
                nwr++; wk = k;
                chk("wr_addr", mem_waddr[sel], {a[31:2], 2'b00});
                chk("wr_data", mem_wdata[sel], exp_wdata);
            end
            if (resp_valid[sel]) begin
                got = 1'b1; rk = k;
                break;
            end
            chk("ready_busy", 32'(req_ready[sel]), 32'd0);
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        chk("resp_seen", 32'(got), 32'd1);
        chk("resp_lat", 32'(rk), 32'(e.resp_lat));
        chk("resp_rdata", resp_rdata[sel], e.rdata);
        chk("resp_error", 32'(resp_error[sel]), 32'(e.err));
        chk("ready_in_resp", 32'(req_ready[sel]), 32'd0);
        chk("wr_count", 32'(nwr), (e.wr_lat != 0) ? 32'd1 : 32'd0);
        if (e.wr_lat != 0) chk("wr_lat", 32'(wk), 32'(e.wr_lat));
        held = resp_rdata[sel];
        @(posedge clk); #1;
        chk("resp_pulse", 32'(resp_valid[sel]), 32'd0);
        chk("ready_after", 32'(req_ready[sel]), 32'd1);
        chk("rdata_hold", resp_rdata[sel], held);
    endtask

    initial begin
        int nmw, nrv;
        bk_we = 1'b0; bk_sel = 0; bk_idx = 8'd0; bk_data = 32'd0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_funct3[i] = 3'b000; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_mem_write", 32'(mem_write[i]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_rdata", resp_rdata[i], 32'd0);
            chk("rst_error", 32'(resp_error[i]), 32'd0);
            chk("rst_waddr", mem_waddr[i], 32'd0);
            chk("rst_raddr", mem_raddr[i], 32'd0);
            chk("rst_wdata", mem_wdata[i], 32'd0);
            chk("mem_funct3", 32'(mem_funct3[i]), 32'd2);
            rst[i] = 1'b0;
        end
        #1;
        chk("ready_release0", 32'(req_ready[0]), 32'd1);
        chk("ready_release1", 32'(req_ready[1]), 32'd1);

        // Latency 1: loads
        preload(0, 32'h100, 32'h8899AABB);
        run(0, 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0);
        run(0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 2, 0, 32'h0);
        run(0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 2, 0, 32'h0);
        run(0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0);
        run(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h0);
        // Latency 1: stores
        run(0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF);
        run(0, 1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
        preload(0, 32'h108, 32'h11223344);
        run(0, 1'b1, 3'b000, 32'h10A, 32'h000000FF, 32'h0, 1'b0, 3, 2, 32'h11FF3344);
        chk("mem_after_sb", mem[0][8'h42], 32'h11FF3344);
        preload(0, 32'h108, 32'h11223344);
        run(0, 1'b1, 3'b001, 32'h108, 32'h0000CAFE, 32'h0, 1'b0, 3, 2, 32'h1122CAFE);
        run(0, 1'b0, 3'b010, 32'h108, 32'h0, 32'h1122CAFE, 1'b0, 2, 0, 32'h0);
        // Errors
        run(0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
        run(0, 1'b1, 3'b001, 32'h105, 32'h12345678, 32'h0, 1'b1, 1, 0, 32'h0);
        run(0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
        run(0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
        run(0, 1'b0, 3'b101, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);

        // Latency 3
        preload(1, 32'h100, 32'h0000F00D);
        run(1, 1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFF00D, 1'b0, 4, 0, 32'h0);
        preload(1, 32'h108, 32'h11223344);
        run(1, 1'b1, 3'b000, 32'h109, 32'h000000AB, 32'h0, 1'b0, 5, 4, 32'h1122AB44);

        // Reset during the read phase of a read-modify-write store
        preload(1, 32'h108, 32'h11223344);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'b000;
        req_addr[1] = 32'h109; req_wdata[1] = 32'h000000EE;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(req_ready[1]), 32'd0);
        chk("midrst_mem_write", 32'(mem_write[1]), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
        rst[1] = 1'b0;
        #1;
        chk("midrst_ready_release", 32'(req_ready[1]), 32'd1);
        nmw = 0; nrv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (mem_write[1]) nmw++;
            if (resp_valid[1]) nrv++;
        end
        chk("midrst_no_write", 32'(nmw), 32'd0);
        chk("midrst_no_resp", 32'(nrv), 32'd0);
        chk("midrst_mem", mem[1][8'h42], 32'h11223344);
        run(1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h11223344, 1'b0, 4, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
